// File: rtl/rcv_block_packer.sv
// Receive staging buffer: packs four 32-bit bus words into a 128-bit block
// and queues complete blocks in a first-word-fall-through FIFO.
module rcv_block_packer #(
   parameter int DEPTH = 4,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          wr_en,
   input  logic [31:0]   wr_data,
   input  logic          rcv_deq,
   input  logic          fix_error,
   output logic [127:0]  rcv_fifo_out,
   output logic          rcv_fifo_empty,
   output logic          rcv_fifo_full,
   output logic          framing_error,
   output logic [CW-1:0] count,
   output logic [1:0]    word_idx
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [127:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [95:0]   asm_q;

   logic wr_live;
   logic push_ok;
   logic push;
   logic pop;

   always_comb begin
      wr_live = wr_en && !fix_error;
      // A pop in the same cycle frees the slot the push needs.
      push_ok = (count != FULL_CNT) || rcv_deq;
      push    = wr_live && (word_idx == 2'd3) && push_ok;
      pop     = rcv_deq && (count != '0);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         word_idx      <= '0;
         asm_q         <= '0;
         framing_error <= 1'b0;
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         count         <= '0;
      end else begin
         if (fix_error) begin
            word_idx      <= '0;
            asm_q         <= '0;
            framing_error <= 1'b0;
         end else if (wr_en) begin
            if (word_idx != 2'd3) begin
               case (word_idx)
                  2'd0:    asm_q[95:64] <= wr_data;
                  2'd1:    asm_q[63:32] <= wr_data;
                  default: asm_q[31:0]  <= wr_data;
               endcase
               word_idx <= word_idx + 2'd1;
            end else if (push) begin
               word_idx <= '0;
            end else begin
               // Overrun: drop the word, keep the three held words for a retry.
               framing_error <= 1'b1;
            end
         end

         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);

         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push && !reset) mem[wr_ptr] <= {asm_q, wr_data};
   end

   always_comb begin
      rcv_fifo_out   = (count != '0) ? mem[rd_ptr] : '0;
      rcv_fifo_empty = (count == '0);
      rcv_fifo_full  = (count == FULL_CNT);
   end

endmodule

// File: tb/tb_rcv_block_packer.sv
// Bench for rcv_block_packer: queue-based block model checked every cycle,
// plus literal expectations from the directed scenarios.
module tb_rcv_block_packer;

   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH + 1);

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          wr_en = 1'b0;
   logic [31:0]   wr_data = '0;
   logic          rcv_deq = 1'b0;
   logic          fix_error = 1'b0;
   logic [127:0]  rcv_fifo_out;
   logic          rcv_fifo_empty;
   logic          rcv_fifo_full;
   logic          framing_error;
   logic [CW-1:0] count;
   logic [1:0]    word_idx;

   rcv_block_packer #(.DEPTH(DEPTH), .CW(CW)) dut (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
      .rcv_deq(rcv_deq), .fix_error(fix_error), .rcv_fifo_out(rcv_fifo_out),
      .rcv_fifo_empty(rcv_fifo_empty), .rcv_fifo_full(rcv_fifo_full),
      .framing_error(framing_error), .count(count), .word_idx(word_idx)
   );

   always #5 clk = ~clk;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;
   bit          chk_en = 1'b0;

   // Behavioural model: a queue of whole blocks plus the partially assembled words.
   logic [127:0] q[$];
   logic [31:0]  held [3];
   int           m_widx = 0;
   bit           m_ferr = 1'b0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_step(input bit rst, input bit we, input logic [31:0] wd,
                                      input bit dq, input bit fe);
      bit can_pop;
      if (rst) begin
         q.delete();
         m_widx = 0;
         m_ferr = 1'b0;
         return;
      end
      can_pop = dq && (q.size() > 0);
      if (fe) begin
         m_ferr = 1'b0;
         m_widx = 0;
         if (can_pop) void'(q.pop_front());
      end else if (we && m_widx < 3) begin
         held[m_widx] = wd;
         m_widx++;
         if (can_pop) void'(q.pop_front());
      end else if (we) begin
         if (can_pop) void'(q.pop_front());
         if (q.size() < DEPTH) begin
            q.push_back({held[0], held[1], held[2], wd});
            m_widx = 0;
         end else begin
            m_ferr = 1'b1;
         end
      end else if (can_pop) begin
         void'(q.pop_front());
      end
   endfunction

   always @(negedge clk) begin
      if (chk_en) begin
         chk("out",   rcv_fifo_out,   (q.size() > 0) ? q[0] : 128'h0);
         chk("empty", rcv_fifo_empty, q.size() == 0);
         chk("full",  rcv_fifo_full,  q.size() == DEPTH);
         chk("count", count,          q.size());
         chk("widx",  word_idx,       m_widx);
         chk("ferr",  framing_error,  m_ferr);
      end
   end

   task automatic step(input bit rst, input bit we, input logic [31:0] wd,
                       input bit dq, input bit fe);
      reset = rst; wr_en = we; wr_data = wd; rcv_deq = dq; fix_error = fe;
      @(posedge clk);
      model_step(rst, we, wd, dq, fe);
      #1;
      reset = 1'b0; wr_en = 1'b0; rcv_deq = 1'b0; fix_error = 1'b0;
   endtask

   task automatic wr(input logic [31:0] wd);
      step(0, 1, wd, 0, 0);
   endtask

   task automatic idle();
      step(0, 0, 32'h0, 0, 0);
   endtask

   task automatic pop();
      step(0, 0, 32'h0, 1, 0);
   endtask

   initial begin
      step(1, 0, 0, 0, 0);
      chk_en = 1'b1;
      step(1, 0, 0, 0, 0);
      chk("rst_count", count, 0);
      chk("rst_empty", rcv_fifo_empty, 1);
      chk("rst_out", rcv_fifo_out, 128'h0);

      // First block, word order and latency.
      wr(32'h00112233); wr(32'h44556677); wr(32'h8899AABB); wr(32'hCCDDEEFF);
      chk("blk1_out", rcv_fifo_out, 128'h00112233_44556677_8899AABB_CCDDEEFF);
      chk("blk1_count", count, 1);
      chk("blk1_widx", word_idx, 0);
      chk("blk1_empty", rcv_fifo_empty, 0);
      pop();

      // Fill, then overrun on the fifth block.
      for (int b = 0; b < DEPTH; b++)
         for (int w = 0; w < 4; w++) wr($urandom);
      chk("fill_full", rcv_fifo_full, 1);
      chk("fill_count", count, 4);
      for (int w = 0; w < 4; w++) wr($urandom);
      chk("ovr_ferr", framing_error, 1);
      chk("ovr_widx", word_idx, 3);
      idle();
      chk("ovr_sticky", framing_error, 1);
      step(0, 0, 0, 0, 1);
      chk("fix_ferr", framing_error, 0);
      chk("fix_widx", word_idx, 0);
      chk("fix_count", count, 4);

      // Push at full with same-cycle pop lands at the tail.
      wr(32'hA0000001); wr(32'hA0000002); wr(32'hA0000003);
      step(0, 1, 32'hA0000004, 1, 0);
      chk("pp_count", count, 4);
      chk("pp_ferr", framing_error, 0);
      pop(); pop(); pop();
      chk("pp_tail", rcv_fifo_out, 128'hA0000001_A0000002_A0000003_A0000004);
      pop();
      chk("pp_empty", rcv_fifo_empty, 1);

      // Pops from empty are ignored; then wrap pointers with interleaved pops.
      step(1, 0, 0, 0, 0);
      pop(); pop(); pop();
      chk("pe_count", count, 0);
      chk("pe_out", rcv_fifo_out, 128'h0);
      chk("pe_ferr", framing_error, 0);
      for (int b = 0; b < 6; b++) begin
         for (int w = 0; w < 4; w++) step(0, 1, 32'hB000_0000 | (b * 4 + w), (w == 1) && b > 1, 0);
      end
      while (count != 0 && q.size() > 0) pop();
      chk("wrap_drain", rcv_fifo_empty, 1);

      // Reset mid-block discards the partial words.
      wr(32'h11111111); wr(32'h22222222);
      step(1, 0, 0, 0, 0);
      wr(32'hC0000001); wr(32'hC0000002); wr(32'hC0000003); wr(32'hC0000004);
      chk("rmid_count", count, 1);
      chk("rmid_out", rcv_fifo_out, 128'hC0000001_C0000002_C0000003_C0000004);

      // fix_error beats a same-cycle write.
      wr(32'hD1); wr(32'hD2); wr(32'hD3);
      step(0, 1, 32'hD4, 0, 1);
      chk("fxw_widx", word_idx, 0);
      chk("fxw_count", count, 1);

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(199) == 0), ($urandom_range(9) < 6), $urandom,
              ($urandom_range(3) == 0), ($urandom_range(39) == 0));
      end

      idle();
      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
